// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the CPU load/store unit and a word-only DMA port.
// Decodes byte-lane masks, flags misaligned CPU accesses and extends CPU load data.
module dmem_port_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CPU_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [2:0]      cpu_funct3,
    input  logic [XLEN-1:0] cpu_addr,
    input  logic [XLEN-1:0] cpu_wdata,
    output logic [XLEN-1:0] cpu_rdata,
    output logic            cpu_ack,
    output logic            cpu_err,
    input  logic            dma_req,
    input  logic            dma_we,
    input  logic [XLEN-1:0] dma_addr,
    input  logic [XLEN-1:0] dma_wdata,
    output logic [XLEN-1:0] dma_rdata,
    output logic            dma_ack,
    output logic            mem_we,
    output logic [3:0]      mem_amp,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd
);

    localparam int unsigned CntW = $clog2(CPU_MAX + 1);
    localparam logic [CntW-1:0] CpuMax = CntW'(CPU_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StGntC,
        StGntD,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] starve_q, starve_d;
    logic            cpu_ack_q, cpu_err_q, dma_ack_q;
    logic [XLEN-1:0] cpu_rdata_q, dma_rdata_q;

    logic [1:0]      addr_lo;
    logic [1:0]      size;
    logic [3:0]      cpu_amp;
    logic            cpu_mis;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] cpu_ext;
    logic            cpu_win;
    state_e          arb_next;
    logic            dma_addr_unused;

    // DMA is word-only, so its low address bits carry no information.
    assign dma_addr_unused = ^dma_addr[1:0];

    assign addr_lo = cpu_addr[1:0];
    assign size    = cpu_funct3[1:0];

    always_comb begin
        cpu_amp = 4'b0000;
        cpu_mis = 1'b0;
        unique case (size)
            2'b00: cpu_amp = 4'b0001 << addr_lo;
            2'b01: begin
                cpu_amp = cpu_addr[1] ? 4'b1100 : 4'b0011;
                cpu_mis = cpu_addr[0];
            end
            2'b10: begin
                cpu_amp = 4'b1111;
                cpu_mis = (addr_lo != 2'b00);
            end
            default: cpu_amp = 4'b0000;
        endcase
    end

    assign lane_b = 8'(mem_rd >> {addr_lo, 3'b000});
    assign lane_h = 16'(mem_rd >> {cpu_addr[1], 4'b0000});

    always_comb begin
        cpu_ext = mem_rd;
        unique case (size)
            2'b00:   cpu_ext = {{(XLEN-8){lane_b[7] & ~cpu_funct3[2]}}, lane_b};
            2'b01:   cpu_ext = {{(XLEN-16){lane_h[15] & ~cpu_funct3[2]}}, lane_h};
            default: cpu_ext = mem_rd;
        endcase
    end

    // DMA takes the slot only once the CPU has had CPU_MAX grants in a row against it.
    assign cpu_win  = cpu_req && !(dma_req && (starve_q == CpuMax));
    assign arb_next = cpu_win ? StGntC : (dma_req ? StGntD : StIdle);

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            StIdle, StResp: begin
                state_d = arb_next;
                if (arb_next == StGntC && dma_req && starve_q != CpuMax) begin
                    starve_d = starve_q + CntW'(1);
                end else if (arb_next == StGntD) begin
                    starve_d = '0;
                end
            end
            StGntC, StGntD: state_d = StResp;
            default:        state_d = StIdle;
        endcase
        if (!dma_req) begin
            starve_d = '0;
        end
    end

    always_comb begin
        mem_we  = 1'b0;
        mem_amp = 4'b0000;
        mem_a   = '0;
        mem_wd  = '0;
        unique case (state_q)
            StGntC: begin
                mem_we  = cpu_we & ~cpu_mis & ~reset;
                mem_amp = cpu_amp;
                mem_a   = {cpu_addr[XLEN-1:2], 2'b00};
                mem_wd  = cpu_wdata;
            end
            StGntD: begin
                mem_we  = dma_we & ~reset;
                mem_amp = 4'b1111;
                mem_a   = {dma_addr[XLEN-1:2], 2'b00};
                mem_wd  = dma_wdata;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            cpu_ack_q <= (state_q == StGntC);
            cpu_err_q <= (state_q == StGntC) && cpu_mis;
            dma_ack_q <= (state_q == StGntD);
            if (state_q == StGntC) begin
                cpu_rdata_q <= cpu_mis ? '0 : cpu_ext;
            end
            if (state_q == StGntD) begin
                dma_rdata_q <= mem_rd;
            end
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_ack   = dma_ack_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small byte-lane data memory behind it.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_err;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ack;
    logic        mem_we;
    logic [3:0]  mem_amp;
    logic [31:0] mem_a, mem_wd, mem_rd;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    dmem_port_arbiter #(.XLEN(32), .CPU_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_funct3 (cpu_funct3),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_err    (cpu_err),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_rdata  (dma_rdata),
        .dma_ack    (dma_ack),
        .mem_we     (mem_we),
        .mem_amp    (mem_amp),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // The memory aligns unshifted store data to the lowest enabled lane.
    function automatic logic [31:0] align_wd(input logic [3:0] amp, input logic [31:0] wd);
        case (amp)
            4'b0010: return wd << 8;
            4'b0100: return wd << 16;
            4'b1000: return wd << 24;
            4'b1100: return wd << 16;
            default: return wd;
        endcase
    endfunction

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_amp[k]) mem[mem_a[7:2]][8*k +: 8] <= align_wd(mem_amp, mem_wd)[8*k +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " cpu_ack"}, 32'(cpu_ack), 32'd0);
        chk({tag, " dma_ack"}, 32'(dma_ack), 32'd0);
        chk({tag, " cpu_err"}, 32'(cpu_err), 32'd0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, " mem_amp"}, 32'(mem_amp), 32'd0);
        chk({tag, " mem_a"}, mem_a, 32'd0);
        chk({tag, " mem_wd"}, mem_wd, 32'd0);
    endtask

    // Issue one CPU access from IDLE; check the access cycle then the ack cycle.
    task automatic cpu_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] exp_amp, input logic exp_we,
                          input logic exp_err, input logic [31:0] exp_rd);
        cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wd;
        step();
        chk({tag, " gnt amp"}, 32'(mem_amp), 32'(exp_amp));
        chk({tag, " gnt we"}, 32'(mem_we), 32'(exp_we));
        chk({tag, " gnt a"}, mem_a, {addr[31:2], 2'b00});
        chk({tag, " gnt wd"}, mem_wd, wd);
        chk({tag, " gnt no ack"}, 32'(cpu_ack), 32'd0);
        step();
        chk({tag, " ack"}, 32'(cpu_ack), 32'd1);
        chk({tag, " err"}, 32'(cpu_err), 32'(exp_err));
        chk({tag, " resp we"}, 32'(mem_we), 32'd0);
        if (!we || exp_err) chk({tag, " rdata"}, cpu_rdata, exp_rd);
        cpu_req = 1'b0;
        step();
        chk({tag, " ack drop"}, 32'(cpu_ack), 32'd0);
    endtask

    initial begin
        logic exp_d;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
        step();
        step();
        reset = 1'b0;
        chk_quiet("reset");
        chk("reset cpu_rdata", cpu_rdata, 32'h0);
        chk("reset dma_rdata", dma_rdata, 32'h0);

        // Word store/load
        cpu_op("sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0, 32'h0);
        cpu_op("lw", 1'b0, 3'b010, 32'h10, 32'h0, 4'b1111, 1'b0, 1'b0, 32'hDEADBEEF);

        // Byte store to lane 3, signed and unsigned reads
        cpu_op("sb", 1'b1, 3'b000, 32'h13, 32'h000000A5, 4'b1000, 1'b1, 1'b0, 32'h0);
        cpu_op("lb", 1'b0, 3'b000, 32'h13, 32'h0, 4'b1000, 1'b0, 1'b0, 32'hFFFFFFA5);
        cpu_op("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 4'b1000, 1'b0, 1'b0, 32'h000000A5);
        cpu_op("lbu0", 1'b0, 3'b100, 32'h10, 32'h0, 4'b0001, 1'b0, 1'b0, 32'h000000EF);

        // Upper half store, signed and unsigned reads
        cpu_op("sh", 1'b1, 3'b001, 32'h12, 32'h00008001, 4'b1100, 1'b1, 1'b0, 32'h0);
        cpu_op("lh", 1'b0, 3'b001, 32'h12, 32'h0, 4'b1100, 1'b0, 1'b0, 32'hFFFF8001);
        cpu_op("lhu", 1'b0, 3'b101, 32'h12, 32'h0, 4'b1100, 1'b0, 1'b0, 32'h00008001);
        cpu_op("lh lo", 1'b0, 3'b001, 32'h10, 32'h0, 4'b0011, 1'b0, 1'b0, 32'hFFFFBEEF);

        // Misaligned accesses: flagged, no write, zero data
        cpu_op("lw mis", 1'b0, 3'b010, 32'h11, 32'h0, 4'b1111, 1'b0, 1'b1, 32'h0);
        cpu_op("sh mis", 1'b1, 3'b001, 32'h13, 32'h0000FFFF, 4'b1100, 1'b0, 1'b1, 32'h0);
        cpu_op("sw mis", 1'b1, 3'b010, 32'h12, 32'h11111111, 4'b1111, 1'b0, 1'b1, 32'h0);
        cpu_op("lw chk", 1'b0, 3'b010, 32'h10, 32'h0, 4'b1111, 1'b0, 1'b0, 32'h8001BEEF);

        // Both requesters held: C,C,C,C,D repeating, ack one cycle after each access
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h10;
        cpu_wdata = 32'hC0C0C0C0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h13; dma_wdata = 32'hD0D0D0D0;
        for (int i = 0; i < 10; i++) begin
            exp_d = ((i % 5) == 4);
            step();
            chk($sformatf("arb%0d grant", i), mem_wd, exp_d ? 32'hD0D0D0D0 : 32'hC0C0C0C0);
            chk($sformatf("arb%0d a", i), mem_a, 32'h10);
            step();
            chk($sformatf("arb%0d cpu_ack", i), 32'(cpu_ack), 32'(!exp_d));
            chk($sformatf("arb%0d dma_ack", i), 32'(dma_ack), 32'(exp_d));
            if (exp_d) chk($sformatf("arb%0d dma_rdata", i), dma_rdata, 32'h8001BEEF);
            else       chk($sformatf("arb%0d cpu_rdata", i), cpu_rdata, 32'h8001BEEF);
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        step();
        chk_quiet("arb idle");

        // DMA word write with low address bits ignored, read back by CPU
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h1B; dma_wdata = 32'hCAFEF00D;
        step();
        chk("dma wr we", 32'(mem_we), 32'd1);
        chk("dma wr amp", 32'(mem_amp), 32'hF);
        chk("dma wr a", mem_a, 32'h18);
        step();
        chk("dma wr ack", 32'(dma_ack), 32'd1);
        dma_req = 1'b0;
        step();
        cpu_op("lw dma", 1'b0, 3'b010, 32'h18, 32'h0, 4'b1111, 1'b0, 1'b0, 32'hCAFEF00D);

        // Reset during a store's access cycle abandons it
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_funct3 = 3'b010; cpu_addr = 32'h20;
        cpu_wdata = 32'h12345678;
        step();
        chk("rst gnt we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst gnt we off", 32'(mem_we), 32'd0);
        step();
        cpu_req = 1'b0;
        #1;
        chk_quiet("rst after");
        chk("rst cpu_rdata", cpu_rdata, 32'h0);
        reset = 1'b0;
        step();
        chk("rst no late ack", 32'(cpu_ack), 32'd0);
        cpu_op("lw rst", 1'b0, 3'b010, 32'h20, 32'h0, 4'b1111, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
